// File: rtl/cdc_pkg.sv
// Shared types and helpers for the count-delta capture block.
package cdc_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int DROP_W_DEF = 16;
    localparam int SUB_MAX_W  = 64;

    typedef enum logic {
        UNPRIMED = 1'b0,
        PRIMED   = 1'b1
    } cap_state_t;

    // Callers truncate the result to their own width; the low bits of a
    // two's-complement difference do not depend on the discarded high bits.
    function automatic logic [SUB_MAX_W-1:0] wrap_sub(
        input logic [SUB_MAX_W-1:0] a,
        input logic [SUB_MAX_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/delta_fifo.sv
// Synchronous FIFO with a first-word fall-through registered head.
module delta_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_nxt;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_head;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_rd_nxt  = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
        end
    end

    // Head follows the entry behind the one being popped, or the incoming
    // word when the FIFO is (or is about to become) otherwise empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (i_flush) begin
            r_head <= '0;
        end else if (w_do_pop) begin
            if (r_level > LVL_W'(1)) r_head <= r_mem[w_rd_nxt];
            else if (w_do_push)      r_head <= i_push_data;
        end else if (w_do_push && o_empty) begin
            r_head <= i_push_data;
        end
    end

endmodule

// File: rtl/count_delta_capture.sv
// Snapshots a free-running count on each capture strobe and queues the
// wrap-safe delta since the previous snapshot for a valid/ready consumer.
module count_delta_capture
    import cdc_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 8,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         count_in,
    input  logic                     capture,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_delta,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     primed
);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_last_snap;
    logic [DROP_W-1:0] r_drop_count;
    logic [CNT_W-1:0]  w_delta;
    logic              w_cap;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;

    assign w_cap   = capture && !clear;
    assign w_pop   = out_valid && out_ready && !clear;
    assign w_delta = CNT_W'(wrap_sub(SUB_MAX_W'(count_in), SUB_MAX_W'(r_last_snap)));
    assign w_push  = w_cap && (r_state == PRIMED) && (!w_full || w_pop);
    assign w_drop  = w_cap && (r_state == PRIMED) && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= UNPRIMED;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)                             w_state_nxt = UNPRIMED;
        else if (r_state == UNPRIMED && capture) w_state_nxt = PRIMED;
    end

    always_comb begin
        primed = (r_state == PRIMED);
    end

    // The snapshot advances on every capture, dropped ones included, so a
    // lost interval is never folded into the following delta.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_last_snap <= '0;
        else if (w_cap) r_last_snap <= count_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              r_drop_count <= '0;
        else if (clear)                         r_drop_count <= '0;
        else if (w_drop && r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
    end

    delta_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (clear),
        .i_push      (w_push),
        .i_push_data (w_delta),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fill_level),
        .o_head      (out_delta)
    );

    assign out_valid  = !w_empty;
    assign drop_count = r_drop_count;

endmodule

// File: doc/count_delta_capture.md
Name: count_delta_capture

Overview:
- Sits directly downstream of the 32-bit up counter and consumes its `count` output.
- On each capture strobe it snapshots the count and computes the delta since the previous snapshot, modulo 2^CNT_W.
- Deltas are buffered in a small FIFO and drained over a valid/ready interface to the reporting logic.
- Overflowing captures are dropped and tallied.

Parameters:
- CNT_W, 32: width of the count input and of the delta output.
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- reset  in  1  asynchronous, active-high reset.
- count_in  in  CNT_W  live counter value.
- capture  in  1  snapshot strobe, sampled every cycle it is high.
- clear  in  1  synchronous flush and re-prime.
- out_valid  out  1  a delta is available.
- out_ready  in  1  consumer accepts the delta.
- out_delta  out  CNT_W  head-of-FIFO delta.
- fill_level  out  $clog2(DEPTH)+1  number of entries held.
- drop_count  out  DROP_W  captures lost to a full FIFO; saturates.
- primed  out  1  a base snapshot is held.

Behaviour:
- Clock and reset: one clock is used. Reset is asynchronous and active-high on port `reset`. Clock port is `clk`.
- Reset values:
  - out_valid=0, out_delta=0, fill_level=0, drop_count=0, primed=0.
  - FSM=UNPRIMED; last_snap=0; FIFO pointers=0.
- FSM states: UNPRIMED and PRIMED.
  - UNPRIMED with capture=1: last_snap<=count_in, go to PRIMED. Nothing is pushed.
  - PRIMED with capture=1: delta=count_in-last_snap, truncated to CNT_W, so wrap-around is natural (e.g. 0x00000005-0xFFFFFFFE=7). Push delta; last_snap<=count_in.
  - PRIMED with capture=0: hold.
- Push and pop rules:
  - Push is accepted when fill_level<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the delta is discarded and drop_count increments, saturating at 2^DROP_W-1.
  - last_snap is updated even on a drop. The dropped interval is lost, not merged into the next delta.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop: fill_level is unchanged. This is legal when full and when holding 1 entry.
- Output handshake:
  - out_valid = (fill_level!=0).
  - out_delta is the registered FIFO head.
  - While out_valid=1 and out_ready=0, out_delta and out_valid hold stable.
  - out_ready while out_valid=0 has no effect.
- Latency: capture in cycle N into an empty FIFO gives out_valid=1 with the delta in cycle N+1. The same applies for fill-through after a pop.
- Clear (synchronous, highest priority after reset):
  - Empties the FIFO, sets drop_count=0, FSM=UNPRIMED, primed=0.
  - A capture in the same cycle as clear is ignored.
  - A pop in the same cycle as clear is not counted; the consumer must treat data as void once clear is asserted.
- Reset mid-operation: everything returns to reset values immediately; in-flight deltas are lost.
- count_in is used exactly as presented. The block makes no assumption about the counter's enable, so a delta of 0 is legal and is pushed.
- primed mirrors FSM==PRIMED.

Decomposition:
- Shared package cdc_pkg (count-delta-capture):
  - CNT_W_DEF=32, DROP_W_DEF=16.
  - An enum type cap_state_t {UNPRIMED, PRIMED}.
  - A function for wrap-safe subtraction.
- One sub-module: delta_fifo.
  - Synchronous FIFO parameterised by width and DEPTH.
  - Exposes push, pop, full, empty, level and head data.
  - First-word fall-through registered head.
- The top module holds the FSM, last_snap, delta arithmetic, drop counter and clear logic.

Test Plan:
- Prime and single delta: reset, then capture at count=100, then capture at count=130 -> after the first capture primed=1 with no output; one cycle after the second, out_valid=1, out_delta=30, fill_level=1.
- Wrap-around: prime at 0xFFFFFFF0, capture at 0x00000010 -> out_delta=0x20.
- Full and drop: out_ready=0, prime, then 10 captures -> fill_level=8, drop_count=2. Then drain with out_ready=1 -> 8 deltas in order, each stable until accepted.
- Simultaneous push/pop at full: fill_level=8, out_ready=1 and capture the same cycle -> fill_level stays 8, drop_count unchanged, the new delta appears last.
- Clear with capture: 3 entries queued, assert clear together with capture -> next cycle fill_level=0, out_valid=0, primed=0, drop_count=0. The next capture only primes.
- Async reset mid-drain: assert reset between clock edges with 4 entries and a stalled output -> out_valid=0, fill_level=0 immediately, without waiting for a clock edge.
